// File: rtl/bcd_addsub_seq.sv
// Digit-serial signed BCD add/subtract sequencer: one shared single-digit BCD slice
// processes operands LSD-first, then optionally a second pass recomplements a negative result.
module bcd_addsub_seq #(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op,
  input  logic              a_sign,
  input  logic [4*NDIG-1:0] a_bcd,
  input  logic              b_sign,
  input  logic [4*NDIG-1:0] b_bcd,
  output logic              busy,
  output logic              done,
  output logic              res_sign,
  output logic [4*NDIG-1:0] res_bcd,
  output logic              overflow
);

  localparam int W  = 4 * NDIG;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

  // CHECK is revisited after PASS2 so the zero rule and final sign are applied in one place
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PASS1 = 3'd1,
    CHECK = 3'd2,
    PASS2 = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic logic [3:0] nines(input logic [3:0] d);
    nines = 4'd9 - d;
  endfunction

  // Single-digit BCD adder: returns {cout, digit}
  function automatic logic [4:0] bcd_add(input logic [3:0] x, input logic [3:0] y,
                                         input logic cin);
    logic [4:0] t;
    t = {1'b0, x} + {1'b0, y} + {4'b0000, cin};
    if (t > 5'd9) begin
      bcd_add = {1'b1, t[3:0] + 4'd6};
    end else begin
      bcd_add = {1'b0, t[3:0]};
    end
  endfunction

  state_t         state_r, state_s;
  logic           sa_r, sb_r;
  logic [W-1:0]   a_r, b_r, sum_r;
  logic           carry_r;
  logic [CW-1:0]  cnt_r;
  logic           p2_r;
  logic           busy_r, done_r, res_sign_r, overflow_r;
  logic [W-1:0]   res_bcd_r;

  logic [3:0]     x_s, y_s;
  logic           cin_s;
  logic [4:0]     slice_s;
  logic [W-1:0]   sum_nxt_s;
  logic           diff_s, first_s, sum_zero_s;
  logic           fin_sign_s, fin_ovf_s;

  assign diff_s     = sa_r ^ sb_r;
  assign first_s    = (cnt_r == {CW{1'b0}});
  assign sum_zero_s = (sum_r == {W{1'b0}});
  assign slice_s    = bcd_add(x_s, y_s, cin_s);
  assign sum_nxt_s  = W'({slice_s[3:0], sum_r} >> 3'd4);

  // Slice operand selection for the current digit
  always_comb begin
    x_s   = 4'd0;
    y_s   = 4'd0;
    cin_s = 1'b0;
    case (state_r)
      PASS1: begin
        x_s   = (sa_r & ~sb_r) ? nines(a_r[3:0]) : a_r[3:0];
        y_s   = (sb_r & ~sa_r) ? nines(b_r[3:0]) : b_r[3:0];
        cin_s = first_s ? diff_s : carry_r;
      end
      PASS2: begin
        x_s   = nines(sum_r[3:0]);
        y_s   = 4'd0;
        cin_s = first_s ? 1'b1 : carry_r;
      end
      default: begin
        x_s   = 4'd0;
        y_s   = 4'd0;
        cin_s = 1'b0;
      end
    endcase
  end

  // Next-state and final sign/overflow decision
  always_comb begin
    state_s    = state_r;
    fin_sign_s = 1'b0;
    fin_ovf_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = PASS1;
        end else begin
          state_s = IDLE;
        end
      end
      PASS1, PASS2: begin
        if (cnt_r == LAST_DIG) begin
          state_s = CHECK;
        end else begin
          state_s = state_r;
        end
      end
      CHECK: begin
        if (p2_r) begin
          fin_sign_s = 1'b1;
          state_s    = DONE;
        end else if (!diff_s) begin
          fin_sign_s = sa_r;
          fin_ovf_s  = carry_r;
          state_s    = DONE;
        end else if (carry_r) begin
          state_s = DONE;
        end else begin
          state_s = PASS2;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, working registers and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      sa_r       <= 1'b0;
      sb_r       <= 1'b0;
      a_r        <= {W{1'b0}};
      b_r        <= {W{1'b0}};
      sum_r      <= {W{1'b0}};
      carry_r    <= 1'b0;
      cnt_r      <= {CW{1'b0}};
      p2_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      res_sign_r <= 1'b0;
      res_bcd_r  <= {W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            sa_r  <= a_sign;
            sb_r  <= b_sign ^ op;
            a_r   <= a_bcd;
            b_r   <= b_bcd;
            cnt_r <= {CW{1'b0}};
            p2_r  <= 1'b0;
          end
        end
        PASS1, PASS2: begin
          if (state_r == PASS1) begin
            a_r <= a_r >> 3'd4;
            b_r <= b_r >> 3'd4;
          end
          sum_r   <= sum_nxt_s;
          carry_r <= slice_s[4];
          cnt_r   <= (cnt_r == LAST_DIG) ? {CW{1'b0}} : cnt_r + CW'(1);
        end
        CHECK: begin
          if (state_s == PASS2) begin
            p2_r <= 1'b1;
          end
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
      // Results change only as DONE is entered; a magnitude of zero is never negative
      if (state_s == DONE) begin
        res_bcd_r  <= sum_r;
        overflow_r <= fin_ovf_s;
        res_sign_r <= fin_sign_s & ~(sum_zero_s & ~fin_ovf_s);
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign res_sign = res_sign_r;
  assign res_bcd  = res_bcd_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Scoreboard bench for bcd_addsub_seq (NDIG=4): directed vectors push expected results,
// a negedge monitor pops and compares on every done pulse, including latency.
module tb_bcd_addsub_seq;

  localparam int NDIG = 4;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              op;
  logic              a_sign;
  logic [4*NDIG-1:0] a_bcd;
  logic              b_sign;
  logic [4*NDIG-1:0] b_bcd;
  logic              busy;
  logic              done;
  logic              res_sign;
  logic [4*NDIG-1:0] res_bcd;
  logic              overflow;

  typedef struct {
    logic        s;
    logic [15:0] m;
    logic        o;
    int          lat;
    int          t0;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   checks;
  int   failures;

  bcd_addsub_seq #(.NDIG(NDIG)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a_sign   (a_sign),
    .a_bcd    (a_bcd),
    .b_sign   (b_sign),
    .b_bcd    (b_bcd),
    .busy     (busy),
    .done     (done),
    .res_sign (res_sign),
    .res_bcd  (res_bcd),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: latency counted in cycles from the cycle in which start was accepted
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        chk("res_sign", {31'd0, res_sign}, {31'd0, e.s});
        chk("res_bcd", {16'd0, res_bcd}, {16'd0, e.m});
        chk("overflow", {31'd0, overflow}, {31'd0, e.o});
        chk("latency", cyc - e.t0, e.lat);
      end
    end
  end

  task automatic drive(input logic opv, input logic as, input logic [15:0] a,
                       input logic bs, input logic [15:0] b);
    start  = 1'b1;
    op     = opv;
    a_sign = as;
    a_bcd  = a;
    b_sign = bs;
    b_bcd  = b;
  endtask

  task automatic run(input logic opv, input logic as, input logic [15:0] a,
                     input logic bs, input logic [15:0] b,
                     input logic es, input logic [15:0] em, input logic eo, input int el);
    exp_t e;
    @(negedge clk);
    drive(opv, as, a, bs, b);
    e.s = es; e.m = em; e.o = eo; e.lat = el; e.t0 = cyc;
    q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    repeat (14) @(posedge clk);
    #1;
    chk("busy_idle", {31'd0, busy}, 32'd0);
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=%0d pending required=0", q.size());
      q.delete();
    end
  endtask

  initial begin
    cyc = 0; checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; op = 1'b0;
    a_sign = 1'b0; a_bcd = 16'h0; b_sign = 1'b0; b_bcd = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sign", {31'd0, res_sign}, 32'd0);
    chk("rst_bcd", {16'd0, res_bcd}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    //   op    as    A         bs    B          sign  mag       ovf  lat
    run(1'b0, 1'b0, 16'h1234, 1'b0, 16'h5678, 1'b0, 16'h6912, 1'b0, 6);
    run(1'b1, 1'b0, 16'h0005, 1'b0, 16'h0012, 1'b1, 16'h0007, 1'b0, 11);
    run(1'b0, 1'b1, 16'h9999, 1'b1, 16'h0001, 1'b1, 16'h0000, 1'b1, 6);
    run(1'b1, 1'b0, 16'h0042, 1'b0, 16'h0042, 1'b0, 16'h0000, 1'b0, 6);
    run(1'b0, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, 6);
    run(1'b0, 1'b0, 16'h9999, 1'b0, 16'h0001, 1'b0, 16'h0000, 1'b1, 6);
    run(1'b0, 1'b1, 16'h0250, 1'b0, 16'h1000, 1'b0, 16'h0750, 1'b0, 6);
    run(1'b0, 1'b0, 16'h0300, 1'b1, 16'h0800, 1'b1, 16'h0500, 1'b0, 11);
    run(1'b1, 1'b1, 16'h0123, 1'b1, 16'h0456, 1'b0, 16'h0333, 1'b0, 6);
    run(1'b1, 1'b1, 16'h0500, 1'b0, 16'h0250, 1'b1, 16'h0750, 1'b0, 6);
    run(1'b1, 1'b0, 16'h4567, 1'b0, 16'h4568, 1'b1, 16'h0001, 1'b0, 11);

    // Second start while busy is ignored: only the first operation completes
    fork
      run(1'b0, 1'b0, 16'h0011, 1'b0, 16'h0022, 1'b0, 16'h0033, 1'b0, 6);
      begin
        repeat (3) @(negedge clk);
        drive(1'b1, 1'b1, 16'h0777, 1'b0, 16'h0111);
        @(negedge clk);
        start = 1'b0;
      end
    join

    // Reset in the middle of PASS1 aborts with no done and clears outputs
    run(1'b1, 1'b0, 16'h0001, 1'b0, 16'h0003, 1'b1, 16'h0002, 1'b0, 11);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h1111, 1'b0, 16'h2222);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_sign", {31'd0, res_sign}, 32'd0);
    chk("midrst_bcd", {16'd0, res_bcd}, 32'd0);
    chk("midrst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (15) @(posedge clk);

    run(1'b0, 1'b0, 16'h0999, 1'b0, 16'h0001, 1'b0, 16'h1000, 1'b0, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
